// File: rtl/trace_buffer.sv
// trace_buffer: fixed-priority multi-channel event capture into a circular buffer
// with stop/overwrite modes. Define TRACE_TIMESTAMP_EN to stamp each entry with a cycle counter.
module trace_buffer #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int TS_W     = 16,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int CNT_W   = AW + 1,
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = TS_W + CH_W + DATA_W
`else
  localparam int ENTRY_W = CH_W + DATA_W
`endif
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       enable_i,
  input  logic                       wrap_i,
  input  logic                       clear_i,
  input  logic [CHANNELS-1:0]        ev_valid_i,
  input  logic [CHANNELS*DATA_W-1:0] ev_data_i,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [ENTRY_W-1:0]         rd_data_o,
  output logic [CNT_W-1:0]           count_o,
  output logic                       overflow_o,
  output logic [15:0]                drop_count_o
);

  localparam int NV_W = $clog2(CHANNELS + 1);

  if (CHANNELS < 1 || CHANNELS > 8 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      TS_W < 1 || DATA_W < 1) begin : g_param_check
    $error("trace_buffer: unsupported parameter set");
  end

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               overflow_q;
  logic [15:0]        drop_q;

  logic               win_found;
  logic [CH_W-1:0]    win_ch;
  logic [DATA_W-1:0]  win_data;
  logic [NV_W-1:0]    n_valid;
  logic [NV_W-1:0]    losers;
  logic               capture;
  logic               pop;
  logic               full;
  logic               wr_accept;
  logic               overwrite;
  logic               drop_full;
  logic [16:0]        drop_sum;
  logic [15:0]        drop_next;
  logic [ENTRY_W-1:0] entry;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running stamp; deliberately untouched by clear_i.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  assign entry = {ts_q, win_ch, win_data};
`else
  assign entry = {win_ch, win_data};
`endif

  // Scanning from the top down lets the lowest valid channel overwrite the winner last.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    win_data  = '0;
    n_valid   = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (ev_valid_i[k]) begin
        win_found = 1'b1;
        win_ch    = CH_W'(k);
        win_data  = ev_data_i[k*DATA_W +: DATA_W];
        n_valid   = n_valid + NV_W'(1);
      end
    end
  end

  assign capture   = enable_i && win_found;
  assign pop       = rd_valid_o && rd_ready_i;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign wr_accept = capture && (!full || pop);
  assign overwrite = capture && full && !pop && wrap_i;
  assign drop_full = capture && full && !pop && !wrap_i;
  assign losers    = capture ? (n_valid - NV_W'(1)) : '0;

  always_comb begin
    drop_sum  = 17'(drop_q) + 17'(losers) + 17'(drop_full);
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk_i) begin
    if ((wr_accept || overwrite) && !clear_i) begin
      mem[wr_ptr_q] <= entry;
    end
  end

  // When full and wrapping, the write slot equals the read slot, so both pointers move together.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (clear_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (wr_accept || overwrite) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop || overwrite) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({wr_accept, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (overwrite || drop_full) begin
        overflow_q <= 1'b1;
      end
      drop_q <= drop_next;
    end
  end

  assign rd_valid_o   = (count_q != '0);
  assign rd_data_o    = mem[rd_ptr_q];
  assign count_o      = count_q;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer: randomized and directed stimulus against a queue-based reference model;
// a negedge monitor pops expected entries whenever the DUT completes a read handshake.
module tb_trace_buffer;

  localparam int CHANNELS = 4;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 64;
  localparam int TS_W     = 16;
  localparam int CH_W     = 2;
  localparam int CNT_W    = 7;
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W  = TS_W + CH_W + DATA_W;
`else
  localparam int ENTRY_W  = CH_W + DATA_W;
`endif

  logic                       clk_i = 1'b0;
  logic                       reset_ni;
  logic                       enable_i;
  logic                       wrap_i;
  logic                       clear_i;
  logic [CHANNELS-1:0]        ev_valid_i;
  logic [CHANNELS*DATA_W-1:0] ev_data_i;
  logic                       rd_valid_o;
  logic                       rd_ready_i;
  logic [ENTRY_W-1:0]         rd_data_o;
  logic [CNT_W-1:0]           count_o;
  logic                       overflow_o;
  logic [15:0]                drop_count_o;

  logic [ENTRY_W-1:0] exp_q[$];
  int unsigned        exp_ovf;
  int unsigned        exp_drops;
  int unsigned        ts_model;
  bit                 mon_en;
  int                 compared;
  int                 mismatched;

  always #5 clk_i = ~clk_i;

  trace_buffer #(
    .CHANNELS(CHANNELS),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .TS_W    (TS_W)
  ) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .enable_i    (enable_i),
    .wrap_i      (wrap_i),
    .clear_i     (clear_i),
    .ev_valid_i  (ev_valid_i),
    .ev_data_i   (ev_data_i),
    .rd_valid_o  (rd_valid_o),
    .rd_ready_i  (rd_ready_i),
    .rd_data_o   (rd_data_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o),
    .drop_count_o(drop_count_o)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference behaviour: lowest valid channel is captured, others counted as drops,
  // and a full buffer either discards the oldest entry or the new one.
  task automatic model_cycle(input bit en, input bit wrap, input bit clr,
                             input logic [CHANNELS-1:0] valid,
                             input logic [CHANNELS*DATA_W-1:0] data);
    int win;
    int nv;
    logic [ENTRY_W-1:0] e;
    if (clr) begin
      exp_q.delete();
      exp_ovf   = 0;
      exp_drops = 0;
    end else if (en && valid != '0) begin
      nv  = $countones(valid);
      win = -1;
      for (int k = 0; k < CHANNELS; k++) begin
        if (valid[k] && win < 0) win = k;
      end
`ifdef TRACE_TIMESTAMP_EN
      e = {TS_W'(ts_model), CH_W'(win), data[win*DATA_W +: DATA_W]};
`else
      e = {CH_W'(win), data[win*DATA_W +: DATA_W]};
`endif
      exp_drops += nv - 1;
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(e);
      end else if (wrap) begin
        void'(exp_q.pop_front());
        exp_q.push_back(e);
        exp_ovf = 1;
      end else begin
        exp_drops += 1;
        exp_ovf = 1;
      end
      if (exp_drops > 65535) exp_drops = 65535;
    end
    ts_model = (ts_model + 1) % (1 << TS_W);
  endtask

  task automatic applyStimulus(input bit en, input bit wrap, input bit clr, input bit rdy,
                               input logic [CHANNELS-1:0] valid,
                               input logic [CHANNELS*DATA_W-1:0] data);
    @(negedge clk_i);
    enable_i   = en;
    wrap_i     = wrap;
    clear_i    = clr;
    rd_ready_i = rdy;
    ev_valid_i = valid;
    ev_data_i  = data;
    #2;
    model_cycle(en, wrap, clr, valid, data);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, rdy, '0, '0);
  endtask

  task automatic single_event(input int ch, input logic [DATA_W-1:0] d, input bit wrap, input bit rdy);
    logic [CHANNELS-1:0]        v;
    logic [CHANNELS*DATA_W-1:0] flat;
    v = '0;
    flat = '0;
    v[ch] = 1'b1;
    flat[ch*DATA_W +: DATA_W] = d;
    applyStimulus(1'b1, wrap, 1'b0, rdy, v, flat);
  endtask

  task automatic do_clear();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
  endtask

  // Reset is asserted between edges and released just after a rising edge,
  // so the next modelled cycle is the first one the DUT counts.
  task automatic pulse_reset();
    @(negedge clk_i);
    #3 reset_ni = 1'b0;
    #1;
    checkOutput("reset_rd_valid", 64'(rd_valid_o), 64'd0);
    checkOutput("reset_count", 64'(count_o), 64'd0);
    checkOutput("reset_overflow", 64'(overflow_o), 64'd0);
    checkOutput("reset_drop_count", 64'(drop_count_o), 64'd0);
    exp_q.delete();
    exp_ovf   = 0;
    exp_drops = 0;
    @(posedge clk_i);
    #1 reset_ni = 1'b1;
    ts_model = 0;
  endtask

  // Monitor: checks status every cycle and pops an expected entry on each handshake.
  always @(negedge clk_i) begin
    #1;
    if (mon_en && reset_ni) begin
      checkOutput("count", 64'(count_o), 64'(exp_q.size()));
      checkOutput("rd_valid", 64'(rd_valid_o), 64'(exp_q.size() != 0));
      checkOutput("overflow", 64'(overflow_o), 64'(exp_ovf));
      checkOutput("drop_count", 64'(drop_count_o), 64'(exp_drops));
      if (rd_valid_o && rd_ready_i) begin
        if (exp_q.size() == 0) begin
          checkOutput("pop_while_empty", 64'(count_o), 64'd0);
        end else begin
          checkOutput("rd_data", 64'(rd_data_o), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [CHANNELS-1:0]        v;
    logic [CHANNELS*DATA_W-1:0] flat;
    int                         rdy_pct;
    bit                         seg_wrap;

    compared   = 0;
    mismatched = 0;
    mon_en     = 1'b0;
    reset_ni   = 1'b0;
    enable_i   = 1'b0;
    wrap_i     = 1'b0;
    clear_i    = 1'b0;
    rd_ready_i = 1'b0;
    ev_valid_i = '0;
    ev_data_i  = '0;
    exp_ovf    = 0;
    exp_drops  = 0;
    ts_model   = 0;

    #1;
    checkOutput("por_count", 64'(count_o), 64'd0);
    checkOutput("por_rd_valid", 64'(rd_valid_o), 64'd0);
    checkOutput("por_overflow", 64'(overflow_o), 64'd0);
    checkOutput("por_drop_count", 64'(drop_count_o), 64'd0);
    repeat (3) @(posedge clk_i);
    #1 reset_ni = 1'b1;
    ts_model = 0;
    mon_en = 1'b1;

    // First capture five cycles after reset release.
    idle(5, 1'b0);
    single_event(2, 32'hCAFE0002, 1'b0, 1'b0);
    idle(1, 1'b0);
    checkOutput("first_rd_valid", 64'(rd_valid_o), 64'd1);
    checkOutput("first_channel", 64'(rd_data_o[DATA_W +: CH_W]), 64'd2);
    checkOutput("first_data", 64'(rd_data_o[DATA_W-1:0]), 64'hCAFE0002);
`ifdef TRACE_TIMESTAMP_EN
    checkOutput("first_timestamp", 64'(rd_data_o[ENTRY_W-1 -: TS_W]), 64'd5);
`endif
    idle(1, 1'b1);

    // Three simultaneous channels: only the lowest is stored.
    flat = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, flat);
    idle(1, 1'b0);
    checkOutput("prio_count", 64'(count_o), 64'd1);
    checkOutput("prio_drops", 64'(drop_count_o), 64'd2);
    checkOutput("prio_data", 64'(rd_data_o[DATA_W-1:0]), 64'hD0);
    do_clear();

    // Stop mode: 70 events into 64 slots.
    for (int i = 0; i < 70; i++) single_event(1, DATA_W'(i), 1'b0, 1'b0);
    idle(1, 1'b0);
    checkOutput("stop_count", 64'(count_o), 64'd64);
    checkOutput("stop_drops", 64'(drop_count_o), 64'd6);
    checkOutput("stop_overflow", 64'(overflow_o), 64'd1);
    checkOutput("stop_head", 64'(rd_data_o[DATA_W-1:0]), 64'd0);
    idle(DEPTH, 1'b1);
    idle(1, 1'b0);
    checkOutput("stop_drained", 64'(count_o), 64'd0);
    do_clear();

    // Wrap mode: the oldest six are overwritten.
    for (int i = 0; i < 70; i++) single_event(1, DATA_W'(i), 1'b1, 1'b0);
    idle(1, 1'b0);
    checkOutput("wrap_count", 64'(count_o), 64'd64);
    checkOutput("wrap_drops", 64'(drop_count_o), 64'd0);
    checkOutput("wrap_overflow", 64'(overflow_o), 64'd1);
    checkOutput("wrap_head", 64'(rd_data_o[DATA_W-1:0]), 64'd6);
    idle(DEPTH, 1'b1);
    do_clear();

    // Full buffer with simultaneous pop and write, then clear racing a write.
    for (int i = 0; i < DEPTH; i++) single_event(0, DATA_W'($urandom), 1'b0, 1'b0);
    idle(1, 1'b0);
    checkOutput("full_count", 64'(count_o), 64'd64);
    single_event(3, 32'h1234_5678, 1'b0, 1'b1);
    idle(1, 1'b0);
    checkOutput("full_popwr_count", 64'(count_o), 64'd64);
    checkOutput("full_popwr_overflow", 64'(overflow_o), 64'd0);
    v = 4'b0001;
    flat = '0;
    flat[DATA_W-1:0] = 32'hABCD;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, v, flat);
    idle(1, 1'b0);
    checkOutput("clear_count", 64'(count_o), 64'd0);
    checkOutput("clear_drops", 64'(drop_count_o), 64'd0);

    // Reset in the middle of operation with entries buffered.
    for (int i = 0; i < 10; i++) single_event(i % CHANNELS, DATA_W'(100 + i), 1'b0, 1'b0);
    pulse_reset();
    single_event(1, 32'h37, 1'b0, 1'b0);
    idle(1, 1'b0);
    checkOutput("post_reset_count", 64'(count_o), 64'd1);
    checkOutput("post_reset_data", 64'(rd_data_o[DATA_W-1:0]), 64'h37);
    idle(2, 1'b1);

    // Randomized segments with varying consumer pressure and mode.
    for (int seg = 0; seg < 16; seg++) begin
      case ($urandom_range(0, 3))
        0:       rdy_pct = 0;
        1:       rdy_pct = 25;
        2:       rdy_pct = 50;
        default: rdy_pct = 90;
      endcase
      seg_wrap = 1'($urandom);
      for (int c = 0; c < 150; c++) begin
        v = ($urandom_range(0, 2) != 0) ? CHANNELS'($urandom) : '0;
        flat = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus($urandom_range(0, 9) != 0, seg_wrap ^ ($urandom_range(0, 19) == 0),
                      $urandom_range(0, 199) == 0, $urandom_range(0, 99) < rdy_pct, v, flat);
      end
    end

    idle(DEPTH + 2, 1'b1);
    idle(2, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
